// File: rtl/hazard_ctrl_if.sv
// D-stage decode fields into the hazard controller and the stall/forward-select results back.
// Pure wiring bundle: the controller side (slave) is combinational, with no handshake.
interface hazard_ctrl_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] A3_D;
    logic [1:0] tnew_D;
    logic       md_start_D;
    logic       md_div_D;
    logic       md_use_D;

    logic       stall;
    logic [1:0] MFRSD_sel;
    logic [1:0] MFRTD_sel;
    logic [1:0] MFALUAE_sel;
    logic [1:0] MFALUBE_sel;
    logic [1:0] MFWDD_sel;
    logic       md_busy;

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_D, tnew_D,
        input  md_start_D, md_div_D, md_use_D,
        output stall, MFRSD_sel, MFRTD_sel, MFALUAE_sel, MFALUBE_sel, MFWDD_sel, md_busy
    );

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_D, tnew_D,
        output md_start_D, md_div_D, md_use_D,
        input  stall, MFRSD_sel, MFRTD_sel, MFALUAE_sel, MFALUBE_sel, MFWDD_sel, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: shadow E/M/W write tracking, forward selects and stall; all outputs same-cycle.
// Stall freezes D and bubbles E; HAZARD_MD_EN adds the HI/LO busy counter and its stall term.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    logic [4:0] rs_E;
    logic [4:0] rt_E;
    logic [4:0] A3_E;
    logic [1:0] tnew_E;
    logic [4:0] rt_M;
    logic [4:0] A3_M;
    logic [1:0] tnew_M;
    logic [4:0] A3_W;

    logic stall_reg;
    logic stall_md;
    logic stall_all;
    logic md_busy_int;

    // A write to $0 never produces a match, which also covers src == 0.
    function automatic logic hit(input logic [4:0] a3, input logic [4:0] src);
        return (a3 != 5'd0) && (a3 == src);
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] src,
                                         input logic [4:0] a3_m, input logic [1:0] tn_m,
                                         input logic [4:0] a3_w);
        if (hit(a3_m, src) && (tn_m == 2'd0))
            return 2'b10;
        else if (hit(a3_w, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                         input logic [4:0] a3_m, input logic [1:0] tn_m,
                                         input logic [4:0] a3_w);
        if (hit(a3_m, src) && (tn_m == 2'd0))
            return 2'b11;
        else if (hit(a3_w, src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        stall_reg = 1'b0;
        if (hit(A3_E, hz.rs_D) && (tnew_E > hz.tuse_rs_D)) stall_reg = 1'b1;
        if (hit(A3_M, hz.rs_D) && (tnew_M > hz.tuse_rs_D)) stall_reg = 1'b1;
        if (hit(A3_E, hz.rt_D) && (tnew_E > hz.tuse_rt_D)) stall_reg = 1'b1;
        if (hit(A3_M, hz.rt_D) && (tnew_M > hz.tuse_rt_D)) stall_reg = 1'b1;
    end

    assign stall_all      = stall_reg | stall_md;
    assign hz.stall       = stall_all;
    assign hz.md_busy     = md_busy_int;
    assign hz.MFRSD_sel   = fwd_d(hz.rs_D, A3_M, tnew_M, A3_W);
    assign hz.MFRTD_sel   = fwd_d(hz.rt_D, A3_M, tnew_M, A3_W);
    assign hz.MFALUAE_sel = fwd_e(rs_E, A3_M, tnew_M, A3_W);
    assign hz.MFALUBE_sel = fwd_e(rt_E, A3_M, tnew_M, A3_W);
    assign hz.MFWDD_sel   = hit(A3_W, rt_M) ? 2'b11 : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_E   <= 5'd0;
            rt_E   <= 5'd0;
            A3_E   <= 5'd0;
            tnew_E <= 2'd0;
            rt_M   <= 5'd0;
            A3_M   <= 5'd0;
            tnew_M <= 2'd0;
            A3_W   <= 5'd0;
        end else begin
            // Bubble carries no sources either, so it can never request a forward.
            if (stall_all) begin
                rs_E   <= 5'd0;
                rt_E   <= 5'd0;
                A3_E   <= 5'd0;
                tnew_E <= 2'd0;
            end else begin
                rs_E   <= hz.rs_D;
                rt_E   <= hz.rt_D;
                A3_E   <= hz.A3_D;
                tnew_E <= hz.tnew_D;
            end
            rt_M   <= rt_E;
            A3_M   <= A3_E;
            tnew_M <= (tnew_E == 2'd0) ? 2'd0 : tnew_E - 2'd1;
            A3_W   <= A3_M;
        end
    end

`ifdef HAZARD_MD_EN
    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic       md_start_E;
    logic       md_div_E;
    logic [3:0] md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_start_E <= 1'b0;
            md_div_E   <= 1'b0;
            md_cnt     <= 4'd0;
        end else begin
            md_start_E <= hz.md_start_D & ~stall_all;
            md_div_E   <= hz.md_div_D & ~stall_all;
            if (md_start_E)
                md_cnt <= md_div_E ? DIV_LD : MULT_LD;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

    // md_use_D covers mult/div too, so a new start can only enter E once the counter is idle.
    always_ff @(posedge clk) begin
        if (!reset && md_start_E)
            assert (md_cnt == 4'd0);
    end

    assign md_busy_int = md_start_E | (md_cnt != 4'd0);
    assign stall_md    = hz.md_use_D & md_busy_int;
`else
    logic unused_md;
    assign unused_md   = ^{hz.md_start_D, hz.md_div_D, hz.md_use_D};
    assign md_busy_int = 1'b0;
    assign stall_md    = 1'b0;
`endif
endmodule
